// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit and the load extension stage.
// Width codes, FSM state encoding, default timeout, width-class helpers.
// No logic of its own.
package load_store_unit_pkg;

    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    // Width codes carried on req_aluOP / load_aluOP
    localparam logic [5:0] OP_BYTE  = 6'd0;
    localparam logic [5:0] OP_HALF  = 6'd1;
    localparam logic [5:0] OP_WORD  = 6'd2;
    localparam logic [5:0] OP_BYTEU = 6'd3;
    localparam logic [5:0] OP_HALFU = 6'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_DONE   = 2'd3
    } lsu_state_e;

    function automatic logic op_is_byte(input logic [5:0] op);
        return (op == OP_BYTE) || (op == OP_BYTEU);
    endfunction

    function automatic logic op_is_half(input logic [5:0] op);
        return (op == OP_HALF) || (op == OP_HALFU);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request / memory / load-result bundle of the load/store unit.
// No latency (wires only).
// Backpressure via req_ready (core side) and mem_gnt (memory side).
// slave : load_store_unit view; master : core + memory (testbench) view.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [5:0]  req_aluOP;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] load;
    logic [5:0]  load_aluOP;
    logic        load_valid;
    logic        st_done;
    logic        err_misalign;
    logic        err_timeout;

    modport slave (
        input  req_valid, req_store, req_aluOP, req_addr, req_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
               load, load_aluOP, load_valid, st_done, err_misalign, err_timeout
    );

    modport master (
        output req_valid, req_store, req_aluOP, req_addr, req_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
               load, load_aluOP, load_valid, st_done, err_misalign, err_timeout
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: store strobes/replicated data, misalign check, load lane extract.
// Latency: combinational.
// Backpressure: none.
// Ports: i_st_op/i_st_off/i_wdata -> o_misalign/o_wstrb/o_wdata (request side);
//        i_ld_op/i_ld_off/i_rdata -> o_rdata (read word shifted down, masked to width).
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [5:0]  i_st_op,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_wdata,
    output logic        o_misalign,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    input  logic [5:0]  i_ld_op,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_rdata
);
    logic [31:0] w_shifted;

    always_comb begin
        o_misalign = 1'b0;
        o_wstrb    = 4'b0000;
        o_wdata    = i_wdata;
        if (op_is_byte(i_st_op)) begin
            o_wstrb = 4'b0001 << i_st_off;
            o_wdata = {4{i_wdata[7:0]}};
        end else if (op_is_half(i_st_op)) begin
            o_misalign = i_st_off[0];
            o_wstrb    = 4'b0011 << i_st_off;
            o_wdata    = {2{i_wdata[15:0]}};
        end else if (i_st_op == OP_WORD) begin
            o_misalign = |i_st_off;
            o_wstrb    = 4'b1111;
        end else begin
            // Undefined width codes are rejected like misaligned accesses
            o_misalign = 1'b1;
        end
    end

    assign w_shifted = i_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        o_rdata = w_shifted;
        if (op_is_byte(i_ld_op)) begin
            o_rdata = {24'h0, w_shifted[7:0]};
        end else if (op_is_half(i_ld_op)) begin
            o_rdata = {16'h0, w_shifted[15:0]};
        end
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access, request latch, grant/rvalid timeout.
// Latency: store 2 cycles accept->st_done, load 3 cycles accept->load_valid (best case).
// Backpressure: req_ready only in IDLE; mem_req held until mem_gnt or timeout.
// Ports: clk, rst_n (async active-low), bus (load_store_unit_if.slave).
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
(
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    lsu_state_e       r_state;
    lsu_state_e       w_state_nxt;
    logic             r_store;
    logic [5:0]       r_op;
    logic [29:0]      r_word_addr;
    logic [1:0]       r_off;
    logic [3:0]       r_wstrb;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_load;
    logic [5:0]       r_load_op;
    logic             r_err_misalign;
    logic             r_err_timeout;

    logic             w_al_misalign;
    logic [3:0]       w_al_wstrb;
    logic [31:0]      w_al_wdata;
    logic [31:0]      w_al_rdata;
    logic             w_accept;
    logic             w_misalign;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_capture;
    logic             w_timeout;
    logic             w_cnt_last;

    lsu_lane_align u_align (
        .i_st_op    (bus.req_aluOP),
        .i_st_off   (bus.req_addr[1:0]),
        .i_wdata    (bus.req_wdata),
        .o_misalign (w_al_misalign),
        .o_wstrb    (w_al_wstrb),
        .o_wdata    (w_al_wdata),
        .i_ld_op    (r_op),
        .i_ld_off   (r_off),
        .i_rdata    (bus.mem_rdata),
        .o_rdata    (w_al_rdata)
    );

    // Last stalled cycle before giving up on the memory
    assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_misalign  = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (w_al_misalign) begin
                        w_misalign = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_gnt) begin
                    if (r_store) begin
                        w_state_nxt = S_DONE;
                    end else if (bus.mem_rvalid) begin
                        // Grant and data in the same cycle: skip WAIT_R
                        w_capture   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_WAIT_R;
                    end
                end else if (w_cnt_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_WAIT_R: begin
                if (bus.mem_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_cnt_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store        <= 1'b0;
            r_op           <= 6'd0;
            r_word_addr    <= 30'd0;
            r_off          <= 2'd0;
            r_wstrb        <= 4'd0;
            r_wdata        <= 32'd0;
            r_cnt          <= '0;
            r_load         <= 32'd0;
            r_load_op      <= 6'd0;
            r_err_misalign <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_store     <= bus.req_store;
                r_op        <= bus.req_aluOP;
                r_word_addr <= bus.req_addr[31:2];
                r_off       <= bus.req_addr[1:0];
                r_wstrb     <= bus.req_store ? w_al_wstrb : 4'd0;
                r_wdata     <= w_al_wdata;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // load/load_aluOP only move when a load completes
            if (w_capture) begin
                r_load    <= w_al_rdata;
                r_load_op <= r_op;
            end
            r_err_misalign <= w_misalign;
            r_err_timeout  <= w_timeout;
        end
    end

    assign bus.req_ready    = (r_state == S_IDLE);
    assign bus.mem_req      = (r_state == S_REQ);
    assign bus.mem_we       = (r_state == S_REQ) & r_store;
    assign bus.mem_addr     = {r_word_addr, 2'b00};
    assign bus.mem_wstrb    = r_wstrb;
    assign bus.mem_wdata    = r_wdata;
    assign bus.load         = r_load;
    assign bus.load_aluOP   = r_load_op;
    assign bus.load_valid   = (r_state == S_DONE) & ~r_store;
    assign bus.st_done      = (r_state == S_DONE) & r_store;
    assign bus.err_misalign = r_err_misalign;
    assign bus.err_timeout  = r_err_timeout;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (TIMEOUT_CYC = 4).
// Drives on the falling edge, samples on the falling edge (outputs are registered).
// Memory side modelled per transaction: grant delay, rvalid delay, same-cycle option.
module tb_load_store_unit;

    typedef struct {
        logic        st;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          g;
        int          r;
        bit          same;
        logic        exp_mis;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wd;
        logic [31:0] exp_ld;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    logic [31:0] last_ld;
    logic [5:0]  last_op;
    vec_t tbl[15];

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int g, input int r, input bit same,
                                input logic mis, input logic [31:0] maddr, input logic [3:0] strb,
                                input logic [31:0] wd, input logic [31:0] ld);
        vec_t v;
        v.st = st; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.g = g; v.r = r; v.same = same;
        v.exp_mis = mis; v.exp_maddr = maddr; v.exp_strb = strb; v.exp_wd = wd; v.exp_ld = ld;
        return v;
    endfunction

    // Reference: byte/lane arithmetic straight from the width rules
    function automatic vec_t mk_rand();
        vec_t v;
        int   off;
        bit   is_b, is_h, is_w;
        v.st    = 1'($urandom_range(0, 1));
        v.op    = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(5, 63)) : 6'($urandom_range(0, 4));
        v.addr  = $urandom();
        v.wdata = $urandom();
        v.rdata = $urandom();
        v.g     = $urandom_range(0, 3);
        v.r     = $urandom_range(0, 3);
        v.same  = ($urandom_range(0, 3) == 0);
        off  = int'(v.addr % 4);
        is_b = (v.op == 6'd0) || (v.op == 6'd3);
        is_h = (v.op == 6'd1) || (v.op == 6'd4);
        is_w = (v.op == 6'd2);
        v.exp_mis   = !(is_b || (is_h && (off % 2 == 0)) || (is_w && off == 0));
        v.exp_maddr = v.addr - (v.addr % 4);
        v.exp_strb  = is_b ? 4'(1 << off) : is_h ? 4'(3 << off) : 4'hF;
        v.exp_wd    = is_b ? 32'(v.wdata % 256) * 32'h01010101 :
                      is_h ? 32'(v.wdata % 65536) * 32'h00010001 : v.wdata;
        v.exp_ld    = is_b ? (v.rdata / (32'd1 << (8 * off))) % 256 :
                      is_h ? (v.rdata / (32'd1 << (8 * off))) % 65536 : v.rdata;
        return v;
    endfunction

    task automatic drive_req(input vec_t v);
        bus.req_valid = 1'b1;
        bus.req_store = v.st;
        bus.req_aluOP = v.op;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
    endtask

    // Runs one request; if hold, keeps req_valid high with nxt presented while busy.
    task automatic run_txn(input vec_t v, input bit noise, input bit hold, input vec_t nxt);
        int    exp_k;
        logic  gnt;
        logic  rv;
        logic  nrv;
        string dn;
        chk("ready_idle", 32'(bus.req_ready), 32'd1);
        drive_req(v);
        if (v.exp_mis) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            chk("misalign_pulse", 32'(bus.err_misalign), 32'd1);
            chk("misalign_no_memreq", 32'(bus.mem_req), 32'd0);
            chk("misalign_ready", 32'(bus.req_ready), 32'd1);
            @(negedge clk);
            chk("misalign_once", 32'(bus.err_misalign), 32'd0);
            chk("misalign_no_memreq2", 32'(bus.mem_req), 32'd0);
            chk("misalign_load_hold", bus.load, last_ld);
            return;
        end
        dn    = v.st ? "st_done" : "load_valid";
        exp_k = v.st ? 2 + v.g : (v.same ? 2 + v.g : 3 + v.g + v.r);
        for (int k = 1; k <= exp_k; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) drive_req(nxt);
                else bus.req_valid = 1'b0;
            end
            chk("busy_not_ready", 32'(bus.req_ready), 32'd0);
            chk("mem_req", 32'(bus.mem_req), 32'(k <= 1 + v.g));
            if (k <= 1 + v.g) begin
                chk("mem_addr", bus.mem_addr, v.exp_maddr);
                chk("mem_we", 32'(bus.mem_we), 32'(v.st));
                if (v.st) begin
                    chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(v.exp_strb));
                    chk("mem_wdata", bus.mem_wdata, v.exp_wd);
                end
            end
            chk(dn, 32'(v.st ? bus.st_done : bus.load_valid), 32'(k == exp_k));
            chk("no_error", 32'(bus.err_timeout | bus.err_misalign), 32'd0);
            gnt = (k == 1 + v.g);
            rv  = !v.st && (v.same ? (k == 1 + v.g) : (k == 2 + v.g + v.r));
            nrv = 1'b0;
            if (noise) begin
                if (k < 1 + v.g) nrv = 1'($urandom_range(0, 1));
                if (!v.st && !v.same && k > 1 + v.g && k <= 2 + v.g + v.r)
                    gnt = gnt | 1'($urandom_range(0, 1));
            end
            bus.mem_gnt    = gnt;
            bus.mem_rvalid = rv | nrv;
            bus.mem_rdata  = rv ? v.rdata : $urandom();
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (!v.st) begin
            chk("load_data", bus.load, v.exp_ld);
            chk("load_aluOP", 32'(bus.load_aluOP), 32'(v.op));
            last_ld = v.exp_ld;
            last_op = v.op;
        end
        @(negedge clk);
        chk({dn, "_once"}, 32'(v.st ? bus.st_done : bus.load_valid), 32'd0);
        chk("ready_after", 32'(bus.req_ready), 32'd1);
        chk("load_hold", bus.load, last_ld);
        chk("load_aluOP_hold", 32'(bus.load_aluOP), 32'(last_op));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_load"}, bus.load, 32'd0);
        chk({tag, "_load_aluOP"}, 32'(bus.load_aluOP), 32'd0);
        chk({tag, "_pulses"}, 32'({bus.load_valid, bus.st_done, bus.err_misalign, bus.err_timeout}), 32'd0);
    endtask

    initial begin
        vec_t v;
        vec_t v2;
        n_chk = 0; n_fail = 0;
        last_ld = 32'd0; last_op = 6'd0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_aluOP = 6'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;

        //            st    op     addr          wdata         rdata         g  r  same mis   maddr         strb   wd            ld
        tbl[0]  = mk(1'b0, 6'd0,  32'h0000_0103, 32'h0,        32'hAABB_CCDD, 0, 0, 0, 1'b0, 32'h0000_0100, 4'h0, 32'h0,        32'h0000_00AA);
        tbl[1]  = mk(1'b1, 6'd1,  32'h0000_0202, 32'h0000_1234, 32'h0,        0, 0, 0, 1'b0, 32'h0000_0200, 4'hC, 32'h1234_1234, 32'h0);
        tbl[2]  = mk(1'b0, 6'd2,  32'h0000_0301, 32'h0,        32'h0,         0, 0, 0, 1'b1, 32'h0,         4'h0, 32'h0,        32'h0);
        tbl[3]  = mk(1'b0, 6'd4,  32'h0000_0002, 32'h0,        32'h8765_4321, 0, 0, 0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,        32'h0000_8765);
        tbl[4]  = mk(1'b0, 6'd1,  32'h0000_1000, 32'h0,        32'h8765_4321, 1, 2, 0, 1'b0, 32'h0000_1000, 4'h0, 32'h0,        32'h0000_4321);
        tbl[5]  = mk(1'b1, 6'd0,  32'h0000_0011, 32'hDEAD_BEEF, 32'h0,        2, 0, 0, 1'b0, 32'h0000_0010, 4'h2, 32'hEFEF_EFEF, 32'h0);
        tbl[6]  = mk(1'b1, 6'd2,  32'h0000_0020, 32'hCAFE_F00D, 32'h0,        3, 0, 0, 1'b0, 32'h0000_0020, 4'hF, 32'hCAFE_F00D, 32'h0);
        tbl[7]  = mk(1'b0, 6'd3,  32'h0000_0401, 32'h0,        32'h1122_3344, 0, 1, 0, 1'b0, 32'h0000_0400, 4'h0, 32'h0,        32'h0000_0033);
        tbl[8]  = mk(1'b1, 6'd1,  32'h0000_0203, 32'h0000_5555, 32'h0,        0, 0, 0, 1'b1, 32'h0,         4'h0, 32'h0,        32'h0);
        tbl[9]  = mk(1'b0, 6'd5,  32'h0000_0000, 32'h0,        32'h0,         0, 0, 0, 1'b1, 32'h0,         4'h0, 32'h0,        32'h0);
        tbl[10] = mk(1'b1, 6'd63, 32'h0000_0004, 32'h0,        32'h0,         0, 0, 0, 1'b1, 32'h0,         4'h0, 32'h0,        32'h0);
        tbl[11] = mk(1'b0, 6'd2,  32'h0000_0500, 32'h0,        32'h1234_5678, 3, 3, 0, 1'b0, 32'h0000_0500, 4'h0, 32'h0,        32'h1234_5678);
        tbl[12] = mk(1'b0, 6'd0,  32'h0000_0102, 32'h0,        32'hAABB_CCDD, 0, 0, 1, 1'b0, 32'h0000_0100, 4'h0, 32'h0,        32'h0000_00BB);
        tbl[13] = mk(1'b1, 6'd3,  32'h0000_0007, 32'h0000_005A, 32'h0,        1, 0, 0, 1'b0, 32'h0000_0004, 4'h8, 32'h5A5A_5A5A, 32'h0);
        tbl[14] = mk(1'b0, 6'd1,  32'hFFFF_FFFE, 32'h0,        32'hBEEF_0000, 2, 0, 1, 1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0,        32'h0000_BEEF);

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_rst");

        // Directed table
        for (int i = 0; i < 15; i++) run_txn(tbl[i], 1'b0, 1'b0, tbl[i]);

        // Back-to-back loads with delayed grant; second request held high while busy
        v  = mk(1'b0, 6'd2, 32'h0000_0600, 32'h0, 32'h0102_0304, 3, 0, 0, 1'b0, 32'h0000_0600, 4'h0, 32'h0, 32'h0102_0304);
        v2 = mk(1'b0, 6'd3, 32'h0000_0703, 32'h0, 32'hF0E0_D0C0, 3, 1, 0, 1'b0, 32'h0000_0700, 4'h0, 32'h0, 32'h0000_00F0);
        run_txn(v, 1'b0, 1'b1, v2);
        run_txn(v2, 1'b0, 1'b0, v2);

        // Timeout waiting for read data
        v = mk(1'b0, 6'd2, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 0, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'h0);
        drive_req(v);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("to_r_memreq", 32'(bus.mem_req), 32'd1);
        bus.mem_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.mem_gnt = 1'b0;
            chk("to_r_busy", 32'(bus.req_ready), 32'd0);
            chk("to_r_no_memreq", 32'(bus.mem_req), 32'd0);
            chk("to_r_no_err_yet", 32'(bus.err_timeout), 32'd0);
            chk("to_r_no_lv", 32'(bus.load_valid), 32'd0);
        end
        @(negedge clk);
        chk("to_r_err", 32'(bus.err_timeout), 32'd1);
        chk("to_r_idle", 32'(bus.req_ready), 32'd1);
        chk("to_r_memreq_low", 32'(bus.mem_req), 32'd0);
        chk("to_r_no_lv2", 32'(bus.load_valid), 32'd0);
        @(negedge clk);
        chk("to_r_err_once", 32'(bus.err_timeout), 32'd0);
        chk("to_r_load_hold", bus.load, last_ld);

        // Timeout waiting for grant (store), rvalid noise must be ignored
        v = mk(1'b1, 6'd2, 32'h0000_0044, 32'h1111_2222, 32'h0, 0, 0, 0, 1'b0, 32'h0000_0044, 4'hF, 32'h1111_2222, 32'h0);
        drive_req(v);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.req_valid  = 1'b0;
            bus.mem_rvalid = 1'b1;
            chk("to_g_memreq", 32'(bus.mem_req), 32'd1);
            chk("to_g_no_err_yet", 32'(bus.err_timeout), 32'd0);
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        chk("to_g_err", 32'(bus.err_timeout), 32'd1);
        chk("to_g_memreq_low", 32'(bus.mem_req), 32'd0);
        chk("to_g_idle", 32'(bus.req_ready), 32'd1);
        chk("to_g_no_done", 32'(bus.st_done), 32'd0);
        @(negedge clk);
        chk("to_g_err_once", 32'(bus.err_timeout), 32'd0);

        // Randomized traffic against the reference
        for (int i = 0; i < 200; i++) begin
            v = mk_rand();
            run_txn(v, 1'b1, 1'b0, v);
        end

        // Reset while in WAIT_R, rvalid after release
        v = mk(1'b0, 6'd2, 32'h0000_0800, 32'h0, 32'h9988_7766, 0, 0, 0, 1'b0, 32'h0000_0800, 4'h0, 32'h0, 32'h9988_7766);
        run_txn(tbl[0], 1'b0, 1'b0, tbl[0]);
        drive_req(v);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_gnt   = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        chk("pre_rst_waitr", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n          = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = v.rdata;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_reset_outputs("after_rst");
        end
        bus.mem_rvalid = 1'b0;
        last_ld = 32'd0;
        last_op = 6'd0;

        // Recovery after reset
        run_txn(tbl[1], 1'b0, 1'b0, tbl[1]);
        run_txn(tbl[0], 1'b0, 1'b0, tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, max cycles waiting for mem_gnt or mem_rvalid before error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core presents load/store request.
REQ-005 req_ready  output  1  unit can accept request (high only in IDLE).
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 req_aluOP  input  6  width code: 0 byte, 1 half, 2 word, 3 byte unsigned, 4 half unsigned.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, low lanes significant.
REQ-010 mem_req / mem_we  output  1 / 1  memory request strobe / write enable.
REQ-011 mem_addr  output  32  word-aligned address ({req_addr[31:2],2'b00}).
REQ-012 mem_wstrb / mem_wdata  output  4 / 32  byte-lane enables / lane-shifted store data.
REQ-013 mem_gnt / mem_rvalid / mem_rdata  input  1 / 1 / 32  grant, read-data valid, read word.
REQ-014 load / load_aluOP / load_valid  output  32 / 6 / 1  lane-shifted raw load word (selected byte/half in bits [7:0]/[15:0], upper bits zero), latched width code, one-cycle valid pulse; feeds the load extension stage.
REQ-015 st_done / err_misalign / err_timeout  output  1 / 1 / 1  one-cycle completion and error pulses.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT_R, DONE.
REQ-017 IDLE: on req_valid, latch store flag, aluOP, addr[1:0], shifted data and strobes; go to REQ, or assert err_misalign for one cycle and stay in IDLE if misaligned.
REQ-018 Misaligned SHALL mean half (1,4) with addr[0]=1, word (2) with addr[1:0]!=0; codes 5-63 SHALL also raise err_misalign; no memory access occurs.
REQ-019 Store strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; mem_wdata = req_wdata replicated to the selected lanes.
REQ-020 REQ: mem_req held high with stable addr/we/wstrb/wdata until mem_gnt; on grant, a store goes to DONE, a load goes to WAIT_R.
REQ-021 WAIT_R: on mem_rvalid, load = mem_rdata >> (8*addr[1:0]) masked to the width; go to DONE.
REQ-022 DONE: pulse load_valid (load) or st_done (store) for exactly one cycle, then IDLE; load and load_aluOP SHALL hold until the next load completes.
REQ-023 Best-case latency: store 2 cycles from acceptance to st_done (gnt in first REQ cycle); load 3 cycles (gnt, rvalid next cycle).
REQ-024 Wait counter SHALL clear on entry to REQ and to WAIT_R, increment each stalled cycle, and on reaching TIMEOUT_CYC pulse err_timeout and return to IDLE with mem_req low.
REQ-025 mem_rvalid outside WAIT_R and mem_gnt outside REQ SHALL be ignored.
REQ-026 mem_gnt and mem_rvalid high in the same REQ cycle for a load SHALL complete the load directly (REQ -> DONE).

Reset
REQ-027 Reset SHALL force IDLE, zero the counter, and drive all outputs 0 except req_ready=1; reset mid-transaction SHALL abandon it with no pulses.

Structure
REQ-028 Width codes (0-4), FSM state encoding and default TIMEOUT_CYC SHALL live in a shared package, common with the load extension stage.
REQ-029 Lane shift/strobe generation SHALL be a combinational sub-module lsu_lane_align; FSM and counter stay in load_store_unit.

Verification
REQ-030 Load byte, addr 0x103, rdata 0xAABBCCDD, gnt immediate, rvalid next cycle -> mem_addr 0x100, load 0x000000AA, load_aluOP 0, load_valid 3 cycles after acceptance.
REQ-031 Store half, addr 0x202, wdata 0x00001234 -> mem_wstrb 4'b1100, mem_wdata 0x12341234, st_done 2 cycles after acceptance.
REQ-032 Load word, addr 0x301 -> err_misalign pulse, mem_req never asserted, req_ready stays 1.
REQ-033 Load with mem_rvalid withheld, TIMEOUT_CYC=4 -> err_timeout after 4 WAIT_R cycles, return to IDLE, no load_valid.
REQ-034 rst_n low during WAIT_R, rvalid asserted after release -> no load_valid, state IDLE, outputs at reset values.
REQ-035 Back-to-back loads, gnt delayed 3 cycles -> request fields stable while mem_req high, second request accepted only in the cycle after DONE.
